store_merge_unit: RTL

Store-side byte-lane packer for the datapath's word-addressed data memory, which has no byte enables. Accepts byte/halfword/word store requests, truncates store data to the access size, and performs a read-modify-write for sub-word stores so that only the addressed lanes change. It is the write-direction counterpart of load-data sign/zero extension: narrow on the way in, extend on the way out.

---
 rtl/store_merge_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/store_merge_unit.sv
// Store merge unit: packs byte/halfword/word stores into a byte-enable-less word memory.
// Latency: word store writes 1 cycle after accept; sub-word store reads, merges, writes at +3.
// Backpressure: o_req_ready is high only in IDLE; one request in flight at a time.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_req_valid / o_req_ready       request handshake
//   i_req_addr, i_req_data, i_req_size   byte address, right-justified data, 00 B / 01 H / 10 W / 11 illegal
//   o_mem_addr                      word address of the captured request
//   o_mem_rd_en / i_mem_rdata       read strobe; data returns the following cycle
//   o_mem_wr_en / o_mem_wdata       write strobe and full merged word
//   o_done                          one-cycle pulse with the write
//   o_misaligned                    one-cycle pulse when a request is rejected
module store_merge_unit #(
  parameter int DATA_WIDTH = 32,  // only 32 (four byte lanes) is meaningful
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  input  logic [1:0]            i_req_size,
  output logic [ADDR_WIDTH-3:0] o_mem_addr,
  output logic                  o_mem_rd_en,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_mem_wr_en,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_done,
  output logic                  o_misaligned
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Request fields captured at accept; only the low address bits are kept
  // here since the word address lives in r_mem_addr.
  typedef struct packed {
    logic [1:0]            size;
    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  state_t                r_state;
  req_t                  r_req;
  logic [ADDR_WIDTH-3:0] r_mem_addr;
  logic                  r_rd_en;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_done;
  logic                  r_misaligned;

  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_merged;

  always_comb begin
    w_illegal = 1'b0;
    case (i_req_size)
      SZ_HALF: w_illegal = i_req_addr[0];
      SZ_WORD: w_illegal = |i_req_addr[1:0];
      SZ_BAD:  w_illegal = 1'b1;
      default: w_illegal = 1'b0;
    endcase
  end

  // Little-endian lane replacement over the word just read back; only used
  // for sub-word sizes, since word stores bypass the read.
  always_comb begin
    w_merged = i_mem_rdata;
    if (r_req.size == SZ_BYTE) begin
      w_merged[{r_req.lane, 3'b000} +: 8] = r_req.data[7:0];
    end else begin
      w_merged[{r_req.lane[1], 4'b0000} +: 16] = r_req.data[15:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_mem_addr   <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // o_req_ready is high here, so valid alone means accept.
          if (i_req_valid) begin
            r_req.size <= i_req_size;
            r_req.lane <= i_req_addr[1:0];
            r_req.data <= i_req_data;
            if (w_illegal) begin
              r_state      <= ERR;
              r_misaligned <= 1'b1;
            end else if (i_req_size == SZ_WORD) begin
              r_state    <= WRITE;
              r_mem_addr <= i_req_addr[ADDR_WIDTH-1:2];
              r_wdata    <= i_req_data;
              r_wr_en    <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_state    <= READ;
              r_mem_addr <= i_req_addr[ADDR_WIDTH-1:2];
              r_rd_en    <= 1'b1;
            end
          end
        end
        READ: begin
          r_rd_en <= 1'b0;
          r_state <= MERGE;
        end
        MERGE: begin
          // Read data is valid in this cycle only.
          r_wdata <= w_merged;
          r_wr_en <= 1'b1;
          r_done  <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        ERR: begin
          r_misaligned <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_rd_en      <= 1'b0;
          r_wr_en      <= 1'b0;
          r_done       <= 1'b0;
          r_misaligned <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  // Ready is masked by reset so nothing is offered while reset is held.
  assign o_req_ready  = (r_state == IDLE) && !i_rst;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rd_en  = r_rd_en;
  assign o_mem_wr_en  = r_wr_en;
  assign o_mem_wdata  = r_wdata;
  assign o_done       = r_done;
  assign o_misaligned = r_misaligned;

endmodule
